// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single fixed-latency unified memory (CPU port + aux DMA/debug port).
// Optional build macro ARB_CPU_PRIO_EN: fixed CPU priority instead of round-robin.
module mem_arbiter #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_ack,
  output logic [DW-1:0] c_rd,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wd,
  output logic          a_ack,
  output logic [DW-1:0] a_rd,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  output logic          gnt,
  output logic          busy
);

  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            c_ack_q;
  logic            a_ack_q;
  logic [DW-1:0]   c_rd_q;
  logic [DW-1:0]   a_rd_q;
  logic            m_en_q;
  logic            m_we_q;
  logic [AW-1:0]   m_adr_q;
  logic [DW-1:0]   m_wd_q;
  logic            gnt_q;
  logic            busy_q;
  logic            win_aux;

  // Winner selection, only meaningful in IDLE when some request is high
`ifdef ARB_CPU_PRIO_EN
  assign win_aux = ~c_req;
`else
  logic last_q;
  assign win_aux = a_req & (~c_req | ~last_q);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      c_ack_q <= 1'b0;
      a_ack_q <= 1'b0;
      c_rd_q  <= '0;
      a_rd_q  <= '0;
      m_en_q  <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_wd_q  <= '0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifndef ARB_CPU_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      c_ack_q <= 1'b0;
      a_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (c_req || a_req) begin
            gnt_q   <= win_aux;
`ifndef ARB_CPU_PRIO_EN
            last_q  <= win_aux;
`endif
            m_adr_q <= win_aux ? a_adr : c_adr;
            m_wd_q  <= win_aux ? a_wd : c_wd;
            m_we_q  <= win_aux ? a_we : c_we;
            m_en_q  <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= CW'(LAT - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Last access cycle: memory data is valid now
            if (!m_we_q) begin
              if (gnt_q) a_rd_q <= m_rd;
              else       c_rd_q <= m_rd;
            end
            if (gnt_q) a_ack_q <= 1'b1;
            else       c_ack_q <= 1'b1;
            m_en_q  <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign c_ack = c_ack_q;
  assign a_ack = a_ack_q;
  assign c_rd  = c_rd_q;
  assign a_rd  = a_rd_q;
  assign m_en  = m_en_q;
  assign m_we  = m_we_q;
  assign m_adr = m_adr_q;
  assign m_wd  = m_wd_q;
  assign gnt   = gnt_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LAT=2 instance for main traffic, LAT=1 instance for back-to-back reads.
module tb_mem_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned LAT1 = 1;

  logic        clk;
  logic        reset;
  logic        init_done;
  int          cyc;
  int          n_cmp;
  int          n_err;

  logic        c_req, c_we, c_ack, a_req, a_we, a_ack;
  logic [31:0] c_adr, c_wd, c_rd, a_adr, a_wd, a_rd;
  logic        m_en, m_we, gnt, busy;
  logic [31:0] m_adr, m_wd, m_rd;

  logic        c_req1, c_we1, c_ack1, a_req1, a_we1, a_ack1;
  logic [31:0] c_adr1, c_wd1, c_rd1, a_adr1, a_wd1, a_rd1;
  logic        m_en1, m_we1, gnt1, busy1;
  logic [31:0] m_adr1, m_wd1, m_rd1;

  logic [31:0] mem [0:63];

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] c_rd;
    logic [31:0] a_rd;
    int          ack_cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd), .c_ack(c_ack), .c_rd(c_rd),
    .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wd(a_wd), .a_ack(a_ack), .a_rd(a_rd),
    .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wd(m_wd), .m_rd(m_rd),
    .gnt(gnt), .busy(busy)
  );

  mem_arbiter #(.AW(32), .DW(32), .LAT(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .c_req(c_req1), .c_we(c_we1), .c_adr(c_adr1), .c_wd(c_wd1), .c_ack(c_ack1), .c_rd(c_rd1),
    .a_req(a_req1), .a_we(a_we1), .a_adr(a_adr1), .a_wd(a_wd1), .a_ack(a_ack1), .a_rd(a_rd1),
    .m_en(m_en1), .m_we(m_we1), .m_adr(m_adr1), .m_wd(m_wd1), .m_rd(m_rd1),
    .gnt(gnt1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preload once, afterwards only the LAT=2 instance writes
  always @(posedge clk) begin
    if (!init_done) begin
      mem[0] <= 32'hA5A5_0001;
      mem[1] <= 32'h5A5A_0002;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'h0000_0000;
    end else if (m_en && m_we) begin
      mem[m_adr[7:2]] <= m_wd;
    end
  end

  assign m_rd  = mem[m_adr[7:2]];
  assign m_rd1 = mem[m_adr1[7:2]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the LAT=2 instance
  int          en_n, we_n;
  logic [31:0] seen_adr;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      en_n = 0;
      we_n = 0;
    end else begin
      if (m_en) begin
        en_n++;
        if (m_we) we_n++;
        seen_adr = m_adr;
      end
      if (c_ack || a_ack) begin
        check("ack_both", 32'(c_ack & a_ack), 32'd0);
        if (q0.size() == 0) begin
          check("spurious_ack", 32'(q0.size()), 32'd1);
        end else begin
          e = q0.pop_front();
          check("ack_port", 32'(a_ack), 32'(e.port));
          check("gnt", 32'(gnt), 32'(e.port));
          check("busy_resp", 32'(busy), 32'd1);
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("c_rd", c_rd, e.c_rd);
          check("a_rd", a_rd, e.a_rd);
          check("m_en_cycles", 32'(en_n), 32'(LAT));
          check("m_we_cycles", 32'(we_n), e.we ? 32'(LAT) : 32'd0);
          check("m_adr", seen_adr, e.adr);
        end
        en_n = 0;
        we_n = 0;
      end
    end
  end

  // Monitor for the LAT=1 instance
  always @(negedge clk) begin
    exp_t e;
    if (reset && (c_ack1 || a_ack1)) begin
      if (q1.size() == 0) begin
        check("spurious_ack1", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        check("ack1_port", 32'(a_ack1), 32'(e.port));
        check("ack1_cycle", 32'(cyc), 32'(e.ack_cyc));
        check("c_rd1", c_rd1, e.c_rd);
      end
    end
  end

  task automatic xfer(input logic port, input logic we, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [31:0] exp_c, input logic [31:0] exp_a);
    exp_t e;
    bit   ok;
    @(negedge clk);
    if (port) begin
      a_req = 1'b1; a_we = we; a_adr = adr; a_wd = wd;
    end else begin
      c_req = 1'b1; c_we = we; c_adr = adr; c_wd = wd;
    end
    e.port = port; e.we = we; e.adr = adr; e.c_rd = exp_c; e.a_rd = exp_a;
    e.ack_cyc = cyc + 1 + int'(LAT);
    q0.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (port ? a_ack : c_ack) ok = 1'b1;
    end
    c_req = 1'b0;
    a_req = 1'b0;
    check("xfer_done", 32'(ok), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   t0;
    int   acks;
    bit   ok;
    cyc = 0; n_cmp = 0; n_err = 0; init_done = 1'b0;
    reset = 1'b0;
    c_req = 0; c_we = 0; c_adr = 0; c_wd = 0;
    a_req = 0; a_we = 0; a_adr = 0; a_wd = 0;
    c_req1 = 0; c_we1 = 0; c_adr1 = 0; c_wd1 = 0;
    a_req1 = 0; a_we1 = 0; a_adr1 = 0; a_wd1 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_c_ack", 32'(c_ack), 32'd0);
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_m_en", 32'(m_en), 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_m_adr", m_adr, 32'd0);
    check("rst_m_wd", m_wd, 32'd0);
    check("rst_c_rd", c_rd, 32'd0);
    check("rst_a_rd", a_rd, 32'd0);
    init_done = 1'b1;
    reset = 1'b1;

    // CPU read, aux write, readbacks
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
    xfer(1'b1, 1'b1, 32'h20, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    check("idle_m_adr_hold", m_adr, 32'h20);
    check("idle_m_en", 32'(m_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    xfer(1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 32'h0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF);

    // Reset during ACCESS abandons the transfer
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h10;
    @(negedge clk);
    check("abort_m_en_before", 32'(m_en), 32'd1);
    reset = 1'b0;
    c_req = 1'b0;
    @(negedge clk);
    check("abort_m_en", 32'(m_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_c_ack", 32'(c_ack), 32'd0);
    check("abort_c_rd", c_rd, 32'd0);
    check("abort_a_rd", a_rd, 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_no_late_ack", 32'(c_ack), 32'd0);
    xfer(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);

    // Both requests held from reset
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_adr = 32'h10;
    a_req = 1'b1; a_we = 1'b0; a_adr = 32'h20;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_CPU_PRIO_EN
      e.port = 1'b0; e.adr = 32'h10; e.c_rd = 32'hDEAD_BEEF; e.a_rd = 32'h0;
`else
      e.port = (k % 2) == 1;
      e.adr  = e.port ? 32'h20 : 32'h10;
      e.c_rd = 32'hDEAD_BEEF;
      e.a_rd = (k == 0) ? 32'h0 : 32'h1234_5678;
`endif
      e.we = 1'b0;
      e.ack_cyc = t0 + int'(LAT) + k * (int'(LAT) + 2);
      q0.push_back(e);
    end
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge clk);
      if (c_ack || a_ack) acks++;
    end
    c_req = 1'b0;
    a_req = 1'b0;
    check("arb_ack_count", 32'(acks), 32'd4);

    // LAT=1 back-to-back CPU reads with request held
    @(negedge clk);
    c_req1 = 1'b1; c_adr1 = 32'h0;
    t0 = cyc + 1;
    e.port = 1'b0; e.we = 1'b0; e.adr = 32'h0; e.a_rd = 32'h0;
    e.c_rd = 32'hA5A5_0001; e.ack_cyc = t0 + 1;
    q1.push_back(e);
    e.c_rd = 32'h5A5A_0002; e.ack_cyc = t0 + 4;
    q1.push_back(e);
    acks = 0;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      @(negedge clk);
      if (c_ack1) begin
        acks++;
        c_adr1 = 32'h4;
      end
    end
    c_req1 = 1'b0;
    check("lat1_ack_count", 32'(acks), 32'd2);

    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (q0.size() == 0) && (q1.size() == 0);
    end
    check("queue_drain", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
